// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - iterative multiply/divide unit owning the HI/LO registers
//
// Ports:
//   clk    pipeline clock, rising edge
//   rstn   asynchronous active-low reset
//   start  EX-stage instruction is an MDU op
//   op     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   A, B   forwarded rs/rt operands
//   flush  abort in-flight operation, blocks start
//   busy   operation in flight (stall request)
//   done   one-cycle pulse after a MULT/DIV result lands in HI/LO
//   hi, lo architectural HI/LO registers
//
// Optional feature macro: MDU_FAST_MUL_EN (single-cycle combinational MULT/MULTU)

module mdu_hilo #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    // acc is the 64-bit partial product for multiply, and {remainder, quotient}
    // for divide (quotient shifts in from the bottom as the dividend shifts out).
    logic [2*WIDTH-1:0] acc;
    // Multiplicand for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0]   opnd;
    // Original dividend, kept for the divide-by-zero result.
    logic [WIDTH-1:0]   a_hold;
    logic               is_div;
    logic               neg_res;
    logic               neg_dvd;
    logic               div_zero;

    // Operand decode at the issue edge.
    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               op_is_mul;
    logic               op_is_div;
    logic               issue_ok;
    logic               launch;

    // One iteration of the datapath.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [2*WIDTH-1:0] acc_next;

    // Sign fix-up of the final result.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] fast_prod;

    // Extending to 64 bits (sign- or zero-) makes the low 64 bits of a plain
    // product correct for both MULT and MULTU.
    always_comb begin
        ext_a     = {{WIDTH{a_neg}}, A};
        ext_b     = {{WIDTH{b_neg}}, B};
        fast_prod = ext_a * ext_b;
    end
`endif

    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & A[WIDTH-1];
        b_neg     = is_signed & B[WIDTH-1];
        mag_a     = a_neg ? (WIDTH'(0) - A) : A;
        mag_b     = b_neg ? (WIDTH'(0) - B) : B;
        op_is_mul = (op == OP_MULT) || (op == OP_MULTU);
        op_is_div = (op == OP_DIV)  || (op == OP_DIVU);
        issue_ok  = (state == S_IDLE) && start && !flush;
`ifdef MDU_FAST_MUL_EN
        launch    = issue_ok && op_is_div;
`else
        launch    = issue_ok && (op_is_mul || op_is_div);
`endif
    end

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        acc_next  = acc;
        if (is_div) begin
            // Restoring step: the remainder stays below the divisor, so the
            // subtraction result always fits back into WIDTH bits.
            if (div_ge) begin
                acc_next = {div_shift[WIDTH-1:0] - opnd, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Shift-add: multiplier bits are consumed from acc[0] while the
            // product grows in from the top.
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_fix = neg_res ? ((2*WIDTH)'(0) - acc) : acc;
        quo_fix  = neg_res ? (WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_fix  = neg_dvd ? (WIDTH'(0) - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_hold   <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_dvd  <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        is_div   <= op_is_div;
                        neg_res  <= a_neg ^ b_neg;
                        neg_dvd  <= a_neg;
                        div_zero <= op_is_div && (B == '0);
                        a_hold   <= A;
                        opnd     <= op_is_div ? mag_b : mag_a;
                        acc      <= {{WIDTH{1'b0}}, (op_is_div ? mag_a : mag_b)};
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= S_CALC;
                    end else if (issue_ok) begin
                        case (op)
                            OP_MTHI: hi <= A;
                            OP_MTLO: lo <= A;
`ifdef MDU_FAST_MUL_EN
                            OP_MULT, OP_MULTU: begin
                                {hi, lo} <= fast_prod;
                                done     <= 1'b1;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        if (!is_div) begin
                            {hi, lo} <= prod_fix;
                        end else if (div_zero) begin
                            hi <= a_hold;
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                        done <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - directed self-checking bench for mdu_hilo

module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_BUSY = 0;
    localparam logic [2:0] FLUSH_OP = 3'b010;
`else
    localparam int MUL_BUSY = 33;
    localparam logic [2:0] FLUSH_OP = 3'b000;
`endif

    always #5 clk = ~clk;

    mdu_hilo dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .op    (op),
        .A     (a),
        .B     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        // Scramble operands so the DUT must have latched them at the issue edge.
        start = 1'b0;
        op    = 3'b111;
        a     = 32'hA5A5_5A5A;
        b     = 32'h5A5A_A5A5;
    endtask

    task automatic mdu_test(input string tag, input logic [2:0] o,
                            input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                            input int exp_busy, input int exp_done);
        int bc;
        int dc;
        issue(o, x, y);
        bc = 0;
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) bc++;
            if (done) dc++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
        check({tag, "_done_pulses"}, 32'(dc), 32'(exp_done));
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        int dc;
        rstn  = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        rstn = 1'b1;

        mdu_test("mult_neg",  3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_BUSY, 1);
        mdu_test("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_BUSY, 1);
        mdu_test("div_neg",   3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1);
        mdu_test("divu_zero", 3'b011, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 33, 1);
        mdu_test("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 1);
        mdu_test("divu_100_7",3'b011, 32'd100,       32'd7,         32'd2,         32'd14,        33, 1);
        mdu_test("div_7_m2",  3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33, 1);
        mdu_test("noop",      3'b110, 32'h1111_1111, 32'h2222_2222, 32'd1,         32'hFFFF_FFFD, 0,  0);
        mdu_test("mthi",      3'b100, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 32'hFFFF_FFFD, 0,  0);
        mdu_test("mtlo",      3'b101, 32'h0000_1111, 32'h0,         32'hDEAD_BEEF, 32'h0000_1111, 0,  0);

        // Flush mid-operation, with an ignored start while busy.
        issue(FLUSH_OP, 32'd7, 32'd9);
        check("flush_busy_on", 32'(busy), 32'h1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 3'b101;
        a     = 32'h9999_9999;
        @(negedge clk);
        start = 1'b0;
        op    = 3'b111;
        repeat (4) @(negedge clk);
        check("flush_still_busy", 32'(busy), 32'h1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_off", 32'(busy), 32'h0);
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dc++;
            @(negedge clk);
        end
        check("flush_no_done", 32'(dc), 32'h0);
        check("flush_hi", hi, 32'hDEAD_BEEF);
        check("flush_lo", lo, 32'h0000_1111);

        // Flush in IDLE blocks MTHI.
        start = 1'b1;
        flush = 1'b1;
        op    = 3'b100;
        a     = 32'h0;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("idle_flush_hi", hi, 32'hDEAD_BEEF);

        // Asynchronous reset mid-CALC.
        issue(3'b010, 32'd100, 32'd3);
        repeat (5) @(negedge clk);
        check("rst_pre_busy", 32'(busy), 32'h1);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_hi", hi, 32'h0);
        check("rst_mid_lo", lo, 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_done", 32'(done), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        mdu_test("post_rst_multu", 3'b001, 32'd6, 32'd7, 32'h0, 32'd42, MUL_BUSY, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
